// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler (NS / EW) with demand latches,
// min/max green, yellow and all-red clearance between every changeover.
// Optional build macro PED_WALK_EN adds a pedestrian walk phase inserted
// after an all-red clearance; without it ped_btn is ignored and walk is 0.
module intersection_phase_scheduler #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 10,
  parameter int T_GREEN_MAX = 30,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_btn,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase,
  output logic       phase_change
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W:0]   E_GMIN   = (CNT_W+1)'(T_GREEN_MIN);
  localparam logic [CNT_W:0]   E_GMAX   = (CNT_W+1)'(T_GREEN_MAX);
  localparam logic [CNT_W:0]   E_YELLOW = (CNT_W+1)'(T_YELLOW);
  localparam logic [CNT_W:0]   E_ALLRED = (CNT_W+1)'(T_ALLRED);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  state_t           state_dly_q, state_dly_d;
  logic             phase_change_q, phase_change_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  logic             tick;
  logic [CNT_W:0]   elapsed;

`ifdef PED_WALK_EN
  localparam logic [CNT_W:0] E_WALK = (CNT_W+1)'(T_WALK);
  logic ped_pend_q, ped_pend_d;
  logic go_ew_q, go_ew_d;
`else
  logic ped_btn_unused;
  assign ped_btn_unused = ped_btn;
`endif

  // Timer holds at its maximum so a long rest in green never wraps back
  // into a short elapsed time.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign tick    = (pre_q == PRE_MAX);
  assign elapsed = {1'b0, timer_q} + (CNT_W+1)'(1);

  // Phase sequencing; every timed transition waits for a tick.
  always_comb begin
    state_d = state_q;
`ifdef PED_WALK_EN
    go_ew_d = go_ew_q;
`endif
    case (state_q)
      NS_GREEN:
        if (tick && elapsed >= E_GMIN && ew_pend_q && (!ns_car || elapsed >= E_GMAX))
          state_d = NS_YELLOW;
      NS_YELLOW:
        if (tick && elapsed == E_YELLOW) state_d = ALLRED_A;
      ALLRED_A:
        if (tick && elapsed == E_ALLRED) begin
          state_d = EW_GREEN;
`ifdef PED_WALK_EN
          if (ped_pend_q) begin
            state_d = PED_WALK;
            go_ew_d = 1'b1;
          end
`endif
        end
      EW_GREEN:
        if (tick && elapsed >= E_GMIN && ns_pend_q && (!ew_car || elapsed >= E_GMAX))
          state_d = EW_YELLOW;
      EW_YELLOW:
        if (tick && elapsed == E_YELLOW) state_d = ALLRED_B;
      ALLRED_B:
        if (tick && elapsed == E_ALLRED) begin
          state_d = NS_GREEN;
`ifdef PED_WALK_EN
          if (ped_pend_q) begin
            state_d = PED_WALK;
            go_ew_d = 1'b0;
          end
`endif
        end
`ifdef PED_WALK_EN
      PED_WALK:
        if (tick && elapsed == E_WALK) state_d = go_ew_q ? EW_GREEN : NS_GREEN;
`endif
      default: state_d = ALLRED_B;
    endcase
  end

  // Prescaler, phase timer, demand latches and change-detect next values.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);

    if (state_d != state_q) timer_d = '0;
    else if (tick)          timer_d = sat_inc(timer_q);
    else                    timer_d = timer_q;

    // Clearing on green entry takes priority over a same-cycle sensor hit.
    ns_pend_d = ns_pend_q;
    if (state_d == NS_GREEN && state_q != NS_GREEN) ns_pend_d = 1'b0;
    else if (ns_car && state_q != NS_GREEN)         ns_pend_d = 1'b1;

    ew_pend_d = ew_pend_q;
    if (state_d == EW_GREEN && state_q != EW_GREEN) ew_pend_d = 1'b0;
    else if (ew_car && state_q != EW_GREEN)         ew_pend_d = 1'b1;

`ifdef PED_WALK_EN
    ped_pend_d = ped_pend_q;
    if (state_d == PED_WALK && state_q != PED_WALK) ped_pend_d = 1'b0;
    else if (ped_btn)                               ped_pend_d = 1'b1;
`endif

    state_dly_d    = state_q;
    phase_change_d = (state_q != state_dly_q);
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ALLRED_B;
      state_dly_q    <= ALLRED_B;
      phase_change_q <= 1'b0;
      pre_q          <= '0;
      timer_q        <= '0;
      ns_pend_q      <= 1'b0;
      ew_pend_q      <= 1'b0;
`ifdef PED_WALK_EN
      ped_pend_q     <= 1'b0;
      go_ew_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      state_dly_q    <= state_dly_d;
      phase_change_q <= phase_change_d;
      pre_q          <= pre_d;
      timer_q        <= timer_d;
      ns_pend_q      <= ns_pend_d;
      ew_pend_q      <= ew_pend_d;
`ifdef PED_WALK_EN
      ped_pend_q     <= ped_pend_d;
      go_ew_q        <= go_ew_d;
`endif
    end
  end

  // Lamp decode straight from the state register.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (state_q)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
`ifdef PED_WALK_EN
      PED_WALK:  walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign phase        = state_q;
  assign phase_change = phase_change_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler (tick every cycle).
module tb_intersection_phase_scheduler;

  localparam int P_MIN  = 4;
  localparam int P_MAX  = 8;
  localparam int P_YEL  = 2;
  localparam int P_AR   = 1;
  localparam int P_WALK = 3;
`ifdef PED_WALK_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ns_car = 1'b0, ew_car = 1'b0, ped_btn = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;
  logic phase_change;

  int checks = 0;
  int failures = 0;

  // Reference model: state codes, ticks spent in state, pending requests.
  int m_state, m_cnt, m_s1, m_s2;
  bit m_nsp, m_ewp, m_pedp, m_next_ew;

  intersection_phase_scheduler #(
    .TICK_DIV(1), .CNT_W(8), .T_GREEN_MIN(P_MIN), .T_GREEN_MAX(P_MAX),
    .T_YELLOW(P_YEL), .T_ALLRED(P_AR), .T_WALK(P_WALK)
  ) dut (
    .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car), .ped_btn(ped_btn),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .phase(phase), .phase_change(phase_change)
  );

  always #5 clk = ~clk;

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  function automatic logic [6:0] exp_lamps(input int s);
    case (s)
      0: return 7'b001_100_0;
      1: return 7'b010_100_0;
      3: return 7'b100_001_0;
      4: return 7'b100_010_0;
      6: return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 5; m_cnt = 0; m_s1 = 5; m_s2 = 5;
    m_nsp = 0; m_ewp = 0; m_pedp = 0; m_next_ew = 0;
  endtask

  task automatic model_step(input bit n, input bit e, input bit p);
    int el, nxt;
    el  = m_cnt + 1;
    nxt = m_state;
    case (m_state)
      0: if (el >= P_MIN && m_ewp && (!n || el >= P_MAX)) nxt = 1;
      1: if (el == P_YEL) nxt = 2;
      2: if (el == P_AR) begin
           if (PED_ON && m_pedp) begin nxt = 6; m_next_ew = 1; end
           else nxt = 3;
         end
      3: if (el >= P_MIN && m_nsp && (!e || el >= P_MAX)) nxt = 4;
      4: if (el == P_YEL) nxt = 5;
      5: if (el == P_AR) begin
           if (PED_ON && m_pedp) begin nxt = 6; m_next_ew = 0; end
           else nxt = 0;
         end
      6: if (el == P_WALK) nxt = m_next_ew ? 3 : 0;
      default: nxt = 5;
    endcase
    if (nxt == 0 && m_state != 0) m_nsp = 0; else if (n && m_state != 0) m_nsp = 1;
    if (nxt == 3 && m_state != 3) m_ewp = 0; else if (e && m_state != 3) m_ewp = 1;
    if (PED_ON) begin
      if (nxt == 6 && m_state != 6) m_pedp = 0; else if (p) m_pedp = 1;
    end
    m_cnt   = (nxt != m_state) ? 0 : m_cnt + 1;
    m_s2    = m_s1;
    m_s1    = m_state;
    m_state = nxt;
  endtask

  task automatic cycle(input bit n, input bit e, input bit p);
    ns_car = n; ew_car = e; ped_btn = p;
    @(posedge clk);
    model_step(n, e, p);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    for (int i = 0; i < cyc; i++) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ns_car = 0; ew_car = 0; ped_btn = 0;
    do_reset(2);
    checks++;
    if (phase !== 3'd5) begin failures++; $display("FAIL reset_phase got=%0d want=5", phase); end
    checks++;
    if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} !== 7'b100_100_0) begin
      failures++;
      $display("FAIL reset_lamps got=%b want=1001000",
               {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk});
    end
    checks++;
    if (phase_change !== 1'b0) begin failures++; $display("FAIL reset_pc got=%b want=0", phase_change); end
    cycle(0, 0, 0);
    checks++;
    if (phase !== 3'd0 || ns_green !== 1'b1) begin
      failures++; $display("FAIL reset_to_ns_green phase=%0d ns_green=%b want 0/1", phase, ns_green);
    end
    checks++;
    if (phase_change !== 1'b0) begin failures++; $display("FAIL reset_pc_early got=%b want=0", phase_change); end
    cycle(0, 0, 0);
    checks++;
    if (phase_change !== 1'b1) begin failures++; $display("FAIL reset_pc_pulse got=%b want=1", phase_change); end
    cycle(0, 0, 0);
    checks++;
    if (phase_change !== 1'b0) begin failures++; $display("FAIL reset_pc_end got=%b want=0", phase_change); end
  endtask

  task automatic test_rest_green();
    int bad_ph, bad_pc;
    bad_ph = 0; bad_pc = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(0, 0, 0);
      if (phase !== 3'(m_state)) bad_ph++;
      if (phase_change !== 1'b0) bad_pc++;
    end
    checks++;
    if (bad_ph != 0) begin failures++; $display("FAIL rest_phase bad_cycles=%0d want=0 phase=%0d", bad_ph, phase); end
    checks++;
    if (bad_pc != 0) begin failures++; $display("FAIL rest_pc bad_cycles=%0d want=0", bad_pc); end
    checks++;
    if (dut.timer_q !== 8'((m_cnt > 255) ? 255 : m_cnt)) begin
      failures++; $display("FAIL rest_timer_sat got=%0d want=255", dut.timer_q);
    end
  endtask

  task automatic test_min_green();
    int exp_ph[8] = '{0, 0, 0, 0, 1, 1, 2, 3};
    do_reset(1);
    cycle(0, 0, 0);                 // now NS_GREEN cycle 0
    for (int k = 1; k <= 7; k++) begin
      cycle(0, (k == 1) ? 1'b1 : 1'b0, 0);
      checks++;
      if (phase !== 3'(exp_ph[k])) begin
        failures++; $display("FAIL min_green_seq cycle=%0d got=%0d want=%0d", k, phase, exp_ph[k]);
      end
      if (k == 6) begin
        checks++;
        if (dut.ew_pend_q !== 1'b1) begin failures++; $display("FAIL ew_pend_held got=%b want=1", dut.ew_pend_q); end
      end
      if (k == 7) begin
        checks++;
        if (dut.ew_pend_q !== 1'b0) begin failures++; $display("FAIL ew_pend_clear got=%b want=0", dut.ew_pend_q); end
      end
    end
  endtask

  task automatic test_extension();
    int gcyc;
    do_reset(1);
    cycle(0, 0, 0);                 // NS_GREEN cycle 0
    cycle(1, 1, 0);
    gcyc = 1;
    while (phase === 3'd0 && gcyc < 50) begin
      cycle(1, 0, 0);
      gcyc++;
    end
    checks++;
    if (gcyc != P_MAX) begin failures++; $display("FAIL ext_green_len got=%0d want=%0d", gcyc, P_MAX); end
    checks++;
    if (phase !== 3'd1) begin failures++; $display("FAIL ext_to_yellow got=%0d want=1", phase); end
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    n = 0;
    while (phase !== 3'd4 && n < 60) begin
      cycle(1, 0, 0);
      n++;
    end
    checks++;
    if (phase !== 3'd4) begin failures++; $display("FAIL reach_ew_yellow got=%0d want=4", phase); end
    ns_car = 1; ew_car = 1;
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0; ns_car = 0; ew_car = 0;
    checks++;
    if (phase !== 3'd5 || ns_red !== 1'b1 || ew_red !== 1'b1) begin
      failures++; $display("FAIL midreset_state phase=%0d reds=%b%b want 5/11", phase, ns_red, ew_red);
    end
    checks++;
    if (dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0) begin
      failures++; $display("FAIL midreset_latches got=%b%b want=00", dut.ns_pend_q, dut.ew_pend_q);
    end
  endtask

  task automatic test_ped();
    int walks, prev_ph, n;
    bit seen_ew;
    int exp_walks, exp_prev;
    exp_walks = PED_ON ? P_WALK : 0;
    exp_prev  = PED_ON ? 6 : 2;
    walks = 0; seen_ew = 0; prev_ph = 0; n = 0;
    do_reset(1);
    cycle(0, 0, 0);
    cycle(0, 1, 1);
    while (!seen_ew && n < 30) begin
      prev_ph = int'(phase);
      cycle(0, 0, 0);
      n++;
      if (walk === 1'b1) walks++;
      if (phase === 3'd3) seen_ew = 1;
      checks++;
      if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} !== exp_lamps(m_state)) begin
        failures++;
        $display("FAIL ped_lamps cycle=%0d got=%b want=%b", n,
                 {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}, exp_lamps(m_state));
      end
    end
    checks++;
    if (walks != exp_walks) begin failures++; $display("FAIL ped_walk_len got=%0d want=%0d", walks, exp_walks); end
    checks++;
    if (!seen_ew || prev_ph != exp_prev) begin
      failures++; $display("FAIL ped_to_ew seen=%0d prev=%0d want 1/%0d", seen_ew, prev_ph, exp_prev);
    end
  endtask

  task automatic test_random();
    bit n, e, p;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      n = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 30) == 0);
      cycle(n, e, p);
      checks++;
      if (phase !== 3'(m_state)) begin
        failures++; $display("FAIL rnd_phase i=%0d got=%0d want=%0d", i, phase, m_state);
      end
      checks++;
      if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} !== exp_lamps(m_state)) begin
        failures++;
        $display("FAIL rnd_lamps i=%0d got=%b want=%b", i,
                 {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}, exp_lamps(m_state));
      end
      checks++;
      if (phase_change !== (m_s1 != m_s2)) begin
        failures++; $display("FAIL rnd_pc i=%0d got=%b want=%b", i, phase_change, (m_s1 != m_s2));
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_rest_green();
    test_min_green();
    test_extension();
    test_reset_mid_yellow();
    test_ped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a two-road intersection (north-south "NS", east-west "EW"). Drives one red/yellow/green set per road.
- Vehicle sensors set demand latches. Green is held for a minimum time and extended on own-road demand up to a maximum. Every changeover passes through yellow and an all-red clearance.
- Sits above the per-road lamp drivers. Replaces free-running fixed-cycle sequencing at intersections.

Parameters:
- TICK_DIV, 10_000_000: clk cycles per timing tick (>=1; 1 = tick every cycle)
- CNT_W, 8: phase timer width in bits
- T_GREEN_MIN, 10: minimum green, in ticks
- T_GREEN_MAX, 30: maximum green while the other road has demand, in ticks (>= T_GREEN_MIN)
- T_YELLOW, 3: yellow duration, in ticks
- T_ALLRED, 1: all-red clearance, in ticks
- T_WALK, 8: pedestrian walk duration, in ticks (PED_WALK_EN only)
- All T_* are >=1 and <2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ns_car  in  1  NS vehicle sensor, level
- ew_car  in  1  EW vehicle sensor, level
- ped_btn  in  1  pedestrian request, level (used only with PED_WALK_EN)
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding
- phase_change  out  1  one-cycle pulse on the cycle after any state change

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - State: ALLRED_B. Prescaler=0, timer=0, demand latches=0.
  - Outputs: ns_red=1, ew_red=1; all other lamps, walk and phase_change =0.
  - Reset mid-operation aborts any phase immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 when count==TICK_DIV-1. With TICK_DIV=1, tick is constant 1.
- Timer:
  - Increments on tick.
  - Cleared to 0 on every state change, so each state starts a full duration.
  - elapsed = timer+1, evaluated on tick cycles.
- States and encoding: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6. Codes 7 and up go to ALLRED_B.
- Transitions (all evaluated only on tick):
  - NS_GREEN -> NS_YELLOW when elapsed>=T_GREEN_MIN and ew_pend and (ns_car=0 or elapsed>=T_GREEN_MAX).
  - No ew_pend: rest in NS_GREEN indefinitely. The timer saturates at 2^CNT_W-1 and does not wrap.
  - NS_YELLOW -> ALLRED_A at elapsed==T_YELLOW.
  - ALLRED_A -> EW_GREEN at elapsed==T_ALLRED.
  - EW_GREEN, EW_YELLOW, ALLRED_B mirror the above, ending in ALLRED_B -> NS_GREEN.
- Demand latches:
  - ns_pend is set on any cycle ns_car=1 while state != NS_GREEN.
  - ns_pend is cleared on the cycle the state enters NS_GREEN. If set and clear coincide, clear wins.
  - ew_pend is symmetric.
- Lamp outputs: combinational decode of the state register, no added latency.
  - ALLRED_A, ALLRED_B and PED_WALK drive both reds.
  - Exactly one lamp per road is lit in every state.
- phase_change: registered compare of state versus state delayed by one cycle.

Optional Feature:
- Macro: PED_WALK_EN.
- Defined:
  - ped_pend is set on ped_btn=1 and cleared on entering PED_WALK (clear wins).
  - At ALLRED_A or ALLRED_B expiry with ped_pend=1, go to PED_WALK, remembering which green is next.
  - PED_WALK: walk=1, both roads red. After T_WALK ticks, go to the remembered green.
- Undefined:
  - ped_btn is ignored, walk is tied 0, and the PED_WALK state is unreachable.
  - Ports are identical in both builds.

Test Plan:
- Setup for all scenarios: TICK_DIV=1, T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, T_WALK=3.
- Reset: assert reset for 2 cycles, release -> ns_red=ew_red=1 and phase=5; 1 cycle later phase=0, ns_green=1, phase_change pulses once.
- Rest in green: no sensors for 300 cycles -> stays in NS_GREEN, timer saturates at 255, no phase_change.
- Min green: ew_car pulsed 1 cycle at cycle 0 of NS_GREEN, ns_car=0 -> NS_YELLOW at cycle 4, ALLRED_A at 6, EW_GREEN at 7; ew_pend clears at 7.
- Extension and max: ew_car pulsed, ns_car held 1 -> NS_GREEN lasts exactly 8 cycles, then yellow.
- Reset mid-yellow: reset asserted during EW_YELLOW -> next edge phase=5 and both reds, latches cleared.
- PED_WALK_EN: ped_btn pulsed during NS_GREEN, ew_car pulsed -> after ALLRED_A, phase=6 and walk=1 for 3 cycles, then EW_GREEN. Without the macro, walk stays 0 throughout.
